// File: rtl/explosion_ctrl.sv
// Explosion walker: queues bomb events, paints flame crosses into the tile map
// and erases each cross once its slot timer runs out.
module explosion_ctrl #(
    parameter int MAP_COLS    = 40,
    parameter int MAP_ROWS    = 30,
    parameter int RANGE       = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int SLOTS       = 6,
    parameter int FLAME_TICKS = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        explode_we,
    input  logic [9:0]  explode_x,
    input  logic [9:0]  explode_y,
    output logic [10:0] map_addr,
    input  logic [1:0]  map_rdata,
    output logic        map_we,
    output logic [1:0]  map_wdata,
    output logic        busy,
    output logic        flames_on,
    output logic        overflow
);

    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int SIW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int TW  = $clog2(FLAME_TICKS + 1);
    localparam int SW  = $clog2(RANGE + 2);

    localparam logic [1:0] T_EMPTY = 2'b00;
    localparam logic [1:0] T_SOFT  = 2'b01;
    localparam logic [1:0] T_HARD  = 2'b10;
    localparam logic [1:0] T_FLAME = 2'b11;

    localparam logic signed [7:0] COLS_S = 8'(MAP_COLS);
    localparam logic signed [7:0] ROWS_S = 8'(MAP_ROWS);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ADDR, S_WAIT, S_DECIDE, S_DONE
    } state_t;

    typedef enum logic [2:0] {D_C, D_U, D_D, D_L, D_R} dir_t;

    state_t state, state_nx;
    dir_t   dir, dir_nx;

    logic [SW-1:0]  step;
    logic           mode_clr;
    logic [5:0]     cur_col, cur_row;
    logic [SIW-1:0] cur_slot;

    logic [11:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           fifo_full, fifo_empty;
    logic           push, pop;

    logic [SLOTS-1:0] slot_busy, slot_exp;
    logic [TW-1:0]    slot_timer [SLOTS];
    logic [5:0]       slot_col [SLOTS];
    logic [5:0]       slot_row [SLOTS];
    logic             exp_any, free_any;
    logic [SIW-1:0]   exp_idx, free_idx;

    logic signed [7:0] base_c, base_r, soff, tcol, trow;
    logic              off_map;
    logic [10:0]       t_addr;

    logic       dec_write, dec_stop, arm_end, last_dir;
    logic [1:0] dec_wdata;

    logic unused_lsbs;
    assign unused_lsbs = ^{explode_x[3:0], explode_y[3:0]};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Event FIFO; a full FIFO still accepts when a pop frees a place this cycle
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign pop  = (state == S_IDLE) && !exp_any && !fifo_empty && free_any;
    assign push = explode_we && (!fifo_full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (explode_we && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr] <= {explode_x[9:4], explode_y[9:4]};
    end

    always_comb begin
        for (int i = 0; i < SLOTS; i++)
            slot_exp[i] = slot_busy[i] && (slot_timer[i] == '0);
    end

    always_comb begin
        exp_any  = 1'b0;
        exp_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (slot_exp[i]) begin
                exp_any = 1'b1;
                exp_idx = SIW'(i);
            end
            if (!slot_busy[i]) begin
                free_any = 1'b1;
                free_idx = SIW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_busy <= '0;
            for (int i = 0; i < SLOTS; i++)
                slot_timer[i] <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++)
                if (slot_busy[i] && slot_timer[i] != '0)
                    slot_timer[i] <= slot_timer[i] - 1'b1;
            if (state == S_DONE) begin
                if (mode_clr) begin
                    slot_busy[cur_slot] <= 1'b0;
                end else begin
                    slot_busy[free_idx]  <= 1'b1;
                    slot_timer[free_idx] <= TW'(FLAME_TICKS);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_DONE && !mode_clr) begin
            slot_col[free_idx] <= cur_col;
            slot_row[free_idx] <= cur_row;
        end
    end

    // Expired slots win over new events so burnt-out flames go away promptly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_clr <= 1'b0;
            cur_col  <= '0;
            cur_row  <= '0;
            cur_slot <= '0;
        end else if (state == S_IDLE) begin
            if (exp_any) begin
                mode_clr <= 1'b1;
                cur_col  <= slot_col[exp_idx];
                cur_row  <= slot_row[exp_idx];
                cur_slot <= exp_idx;
            end else if (pop) begin
                mode_clr           <= 1'b0;
                {cur_col, cur_row} <= fifo_q[rd_ptr];
            end
        end
    end

    assign base_c = signed'({2'b00, cur_col});
    assign base_r = signed'({2'b00, cur_row});
    assign soff   = signed'(8'(step));

    always_comb begin
        tcol = base_c;
        trow = base_r;
        case (dir)
            D_U:     trow = base_r - soff;
            D_D:     trow = base_r + soff;
            D_L:     tcol = base_c - soff;
            D_R:     tcol = base_c + soff;
            default: ;
        endcase
    end

    assign off_map = (tcol < 8'sd0) || (trow < 8'sd0) ||
                     (tcol >= COLS_S) || (trow >= ROWS_S);
    assign t_addr  = 11'(trow[6:0]) * 11'(MAP_COLS) + 11'(tcol[6:0]);

    always_comb begin
        case (dir)
            D_C:     dir_nx = D_U;
            D_U:     dir_nx = D_D;
            D_D:     dir_nx = D_L;
            D_L:     dir_nx = D_R;
            default: dir_nx = D_C;
        endcase
    end

    always_comb begin
        dec_write = 1'b0;
        dec_wdata = T_FLAME;
        dec_stop  = 1'b0;
        priority case (1'b1)
            mode_clr: begin
                dec_wdata = T_EMPTY;
                dec_write = (map_rdata == T_FLAME);
                dec_stop  = (map_rdata != T_FLAME) || (dir == D_C);
            end
            dir == D_C: begin
                dec_write = 1'b1;
                dec_stop  = 1'b1;
            end
            map_rdata == T_HARD: dec_stop = 1'b1;
            map_rdata == T_SOFT: begin
                dec_write = 1'b1;
                dec_stop  = 1'b1;
            end
            default: dec_write = 1'b1;
        endcase
    end

    assign arm_end  = dec_stop || (step == SW'(RANGE));
    assign last_dir = (dir == D_R);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir      <= D_C;
            step     <= '0;
            map_addr <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    dir  <= D_C;
                    step <= '0;
                end
                S_ADDR: begin
                    if (off_map) begin
                        dir  <= dir_nx;
                        step <= SW'(1);
                    end else begin
                        map_addr <= t_addr;
                    end
                end
                S_DECIDE: begin
                    if (arm_end) begin
                        dir  <= dir_nx;
                        step <= SW'(1);
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (exp_any || pop) state_nx = S_LOAD;
            S_LOAD:   state_nx = S_ADDR;
            S_ADDR: begin
                if (!off_map)     state_nx = S_WAIT;
                else if (last_dir) state_nx = S_DONE;
                else              state_nx = S_ADDR;
            end
            S_WAIT:   state_nx = S_DECIDE;
            S_DECIDE: state_nx = (arm_end && last_dir) ? S_DONE : S_ADDR;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        map_we    = 1'b0;
        map_wdata = T_EMPTY;
        if (state == S_DECIDE && dec_write) begin
            map_we    = 1'b1;
            map_wdata = dec_wdata;
        end
    end

    assign flames_on = |slot_busy;

endmodule

// File: tb/tb_explosion_ctrl.sv
// Bench for explosion_ctrl: tile RAM model plus a write scoreboard
// filled with the expected cross pattern for each event.
module tb_explosion_ctrl;

    localparam int FT     = 20;
    localparam int DROP_A = 20 * 40 + 25;

    logic        clk = 1'b0;
    logic        reset;
    logic        explode_we;
    logic [9:0]  explode_x, explode_y;
    logic [10:0] map_addr;
    logic [1:0]  map_rdata;
    logic        map_we;
    logic [1:0]  map_wdata;
    logic        busy, flames_on, overflow;

    logic        tb_we = 1'b0;
    logic [10:0] tb_addr = '0;
    logic [1:0]  tb_data = '0;
    logic [1:0]  mem [1200] = '{default: 2'b00};

    logic [12:0] exp_q [$];
    logic [12:0] e;
    logic        sb_on = 1'b1;
    logic        addr_bad = 1'b0;
    logic        drop_hit = 1'b0;
    int          n_ign = 0, n_clr = 0;
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    explosion_ctrl #(.FLAME_TICKS(FT)) dut (
        .clk        (clk),
        .reset      (reset),
        .explode_we (explode_we),
        .explode_x  (explode_x),
        .explode_y  (explode_y),
        .map_addr   (map_addr),
        .map_rdata  (map_rdata),
        .map_we     (map_we),
        .map_wdata  (map_wdata),
        .busy       (busy),
        .flames_on  (flames_on),
        .overflow   (overflow)
    );

    always @(posedge clk) begin
        if (tb_we)
            mem[tb_addr] <= tb_data;
        else if (map_we && map_addr < 11'd1200)
            mem[map_addr] <= map_wdata;
        map_rdata <= (map_addr < 11'd1200) ? mem[map_addr] : 2'b00;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (map_addr > 11'd1199) addr_bad = 1'b1;
        if (map_we) begin
            if (map_wdata == 2'b11) n_ign++;
            else if (map_wdata == 2'b00) n_clr++;
            if (map_addr == 11'(DROP_A)) drop_hit = 1'b1;
            if (sb_on) begin
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", {19'd0, map_addr, map_wdata},
                          32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("wr", {19'd0, map_addr, map_wdata}, {19'd0, e});
                end
            end
        end
    end

    task automatic exp_wr(input int c, input int r, input logic [1:0] code);
        exp_q.push_back({11'(r * 40 + c), code});
    endtask

    // Full cross on a map with no blocks, off-map tiles dropped
    task automatic push_cross(input int c, input int r, input logic [1:0] code);
        int dx[9] = '{0, 0, 0, 0, 0, -1, -2, 1, 2};
        int dy[9] = '{0, -1, -2, 1, 2, 0, 0, 0, 0};
        for (int i = 0; i < 9; i++) begin
            if (c + dx[i] >= 0 && c + dx[i] < 40 &&
                r + dy[i] >= 0 && r + dy[i] < 30)
                exp_wr(c + dx[i], r + dy[i], code);
        end
    endtask

    task automatic poke(input int c, input int r, input logic [1:0] d);
        @(negedge clk);
        tb_we   = 1'b1;
        tb_addr = 11'(r * 40 + c);
        tb_data = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic fire(input int x, input int y);
        @(posedge clk); #1;
        explode_we = 1'b1;
        explode_x  = 10'(x);
        explode_y  = 10'(y);
        @(posedge clk); #1;
        explode_we = 1'b0;
    endtask

    task automatic run_walk(input string tag, output int cyc, output int idle,
                            output logic fl0);
        int n;
        cyc  = 0;
        idle = 0;
        fl0  = 1'b0;
        n    = 0;
        do begin
            @(negedge clk);
            if (!busy) idle++;
            n++;
        end while (!busy && n < 500);
        if (!busy) begin
            check({tag, "_start_timeout"}, 0, 1);
            return;
        end
        fl0 = flames_on;
        n   = 0;
        while (busy && n < 500) begin
            cyc++;
            @(negedge clk);
            n++;
        end
        if (busy) check({tag, "_end_timeout"}, 0, 1);
    endtask

    initial begin
        int   cyc, idle, nz, quiet, n, bz;
        logic fl0;
        int   xs[5] = '{240, 400, 80, 240, 400};
        int   ys[5] = '{80, 80, 320, 320, 320};

        reset      = 1'b1;
        explode_we = 1'b0;
        explode_x  = '0;
        explode_y  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_map_addr", map_addr, 0);
        check("rst_map_we", map_we, 0);
        check("rst_map_wdata", map_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_flames", flames_on, 0);
        check("rst_overflow", overflow, 0);
        @(negedge clk);
        reset = 1'b0;

        // centre cross, then its timed erase
        push_cross(10, 10, 2'b11);
        push_cross(10, 10, 2'b00);
        fire(160, 160);
        run_walk("t1_ign", cyc, idle, fl0);
        check("t1_busy_cycles", cyc, 29);
        check("t1_flames_on", flames_on, 1);
        run_walk("t4_clr", cyc, idle, fl0);
        check("t4_gap", idle, FT);
        check("t4_clr_cycles", cyc, 29);
        check("t4_flames_during", fl0, 1);
        check("t4_flames_off", flames_on, 0);
        check("t4_queue_empty", exp_q.size(), 0);

        // hard block stops an arm, soft block is destroyed and stops it
        poke(10, 9, 2'b10);
        poke(11, 10, 2'b01);
        poke(12, 10, 2'b01);
        exp_wr(10, 10, 2'b11);
        exp_wr(10, 11, 2'b11);
        exp_wr(10, 12, 2'b11);
        exp_wr(9, 10, 2'b11);
        exp_wr(8, 10, 2'b11);
        exp_wr(11, 10, 2'b11);
        exp_wr(10, 10, 2'b00);
        exp_wr(10, 11, 2'b00);
        exp_wr(10, 12, 2'b00);
        exp_wr(9, 10, 2'b00);
        exp_wr(8, 10, 2'b00);
        exp_wr(11, 10, 2'b00);
        fire(160, 160);
        run_walk("t2_ign", cyc, idle, fl0);
        check("t2_ign_cycles", cyc, 23);
        run_walk("t2_clr", cyc, idle, fl0);
        check("t2_clr_cycles", cyc, 26);
        check("t2_hard_kept", mem[9 * 40 + 10], 2'b10);
        check("t2_beyond_soft", mem[10 * 40 + 12], 2'b01);
        check("t2_behind_hard", mem[8 * 40 + 10], 2'b00);
        check("t2_queue_empty", exp_q.size(), 0);
        poke(10, 9, 2'b00);
        poke(12, 10, 2'b00);

        // corner: U and L arms fall off the map
        push_cross(0, 0, 2'b11);
        push_cross(0, 0, 2'b00);
        fire(0, 0);
        run_walk("t3_ign", cyc, idle, fl0);
        check("t3_ign_cycles", cyc, 19);
        run_walk("t3_clr", cyc, idle, fl0);
        check("t3_clr_cycles", cyc, 19);
        check("t3_queue_empty", exp_q.size(), 0);

        // five events while busy: four queue, the fifth is dropped
        sb_on    = 1'b0;
        n_ign    = 0;
        n_clr    = 0;
        drop_hit = 1'b0;
        fire(80, 80);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 50);
        check("t5_busy_seen", busy, 1);
        @(posedge clk); #1;
        explode_we = 1'b1;
        for (int k = 0; k < 5; k++) begin
            explode_x = 10'(xs[k]);
            explode_y = 10'(ys[k]);
            @(posedge clk); #1;
            if (k == 3) check("t5_ovf_before", overflow, 0);
        end
        explode_we = 1'b0;
        check("t5_ovf_set", overflow, 1);
        quiet = 0;
        n     = 0;
        while (quiet < 3 && n < 5000) begin
            @(negedge clk);
            n++;
            if (!busy && !flames_on) quiet++;
            else quiet = 0;
        end
        check("t5_settled", quiet, 3);
        check("t5_flame_writes", n_ign, 45);
        check("t5_clear_writes", n_clr, 45);
        check("t5_dropped_untouched", drop_hit, 0);
        check("t5_ovf_sticky", overflow, 1);
        nz = 0;
        for (int i = 0; i < 1200; i++)
            if (mem[i] != 2'b00) nz++;
        check("t5_map_clean", nz, 0);
        sb_on = 1'b1;

        // reset during the first RAM wait, with two events still queued
        @(posedge clk); #1;
        explode_we = 1'b1;
        explode_x  = 10'd160;
        explode_y  = 10'd160;
        @(posedge clk); #1;
        explode_x  = 10'd320;
        explode_y  = 10'd240;
        @(posedge clk); #1;
        explode_x  = 10'd400;
        explode_y  = 10'd240;
        @(posedge clk); #1;
        explode_we = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("t6_map_we", map_we, 0);
        check("t6_busy", busy, 0);
        check("t6_flames", flames_on, 0);
        check("t6_overflow", overflow, 0);
        check("t6_map_addr", map_addr, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bz = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) bz++;
        end
        check("t6_fifo_flushed", bz, 0);
        push_cross(20, 15, 2'b11);
        push_cross(20, 15, 2'b00);
        fire(320, 240);
        run_walk("t6_ign", cyc, idle, fl0);
        check("t6_ign_cycles", cyc, 29);
        run_walk("t6_clr", cyc, idle, fl0);
        check("t6_queue_empty", exp_q.size(), 0);
        check("addr_in_range", addr_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
